// File: rtl/atm_account_ledger_if.sv
// Request/response channel between the ATM front-end and the account ledger.
// Both directions use a valid/ready handshake.
interface atm_account_ledger_if #(
    parameter int CARD_W = 8,
    parameter int PIN_W  = 4,
    parameter int BAL_W  = 8,
    parameter int AMT_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [CARD_W-1:0] req_card;
    logic [PIN_W-1:0]  req_pin;
    logic [AMT_W-1:0]  req_amount;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_status;
    logic [BAL_W-1:0]  rsp_balance;
    logic [PIN_W-1:0]  rsp_pin;

    modport master (
        output req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_balance, rsp_pin
    );

    modport slave (
        input  req_valid, req_op, req_card, req_pin, req_amount, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_balance, rsp_pin
    );
endinterface

// File: rtl/atm_account_ledger.sv
// Account store and transaction executor: sequential card search, PIN check
// with retry lockout, then deposit/withdraw/query with overflow protection.
module atm_account_ledger #(
    parameter  int NUM_ACCTS = 4,
    parameter  int CARD_W    = 8,
    parameter  int PIN_W     = 4,
    parameter  int BAL_W     = 8,
    parameter  int AMT_W     = 5,
    parameter  int MAX_TRIES = 3,
    localparam int IDXW      = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_we,
    input  logic [IDXW-1:0]   init_idx,
    input  logic [CARD_W-1:0] init_card,
    input  logic [PIN_W-1:0]  init_pin,
    input  logic [BAL_W-1:0]  init_bal,
    atm_account_ledger_if.slave bus
);
    localparam int SW = BAL_W + 1;
    localparam int FW = 2;

    localparam logic [2:0] ST_OK     = 3'd0;
    localparam logic [2:0] ST_NOCARD = 3'd1;
    localparam logic [2:0] ST_BADPIN = 3'd2;
    localparam logic [2:0] ST_LOCKED = 3'd3;
    localparam logic [2:0] ST_INSUFF = 3'd4;
    localparam logic [2:0] ST_OVFL   = 3'd5;

    localparam logic [1:0] OP_AUTH  = 2'b00;
    localparam logic [1:0] OP_DEP   = 2'b01;
    localparam logic [1:0] OP_WDR   = 2'b10;
    localparam logic [1:0] OP_QUERY = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_EXEC,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [CARD_W-1:0] acct_card_q  [NUM_ACCTS];
    logic [PIN_W-1:0]  acct_pin_q   [NUM_ACCTS];
    logic [BAL_W-1:0]  acct_bal_q   [NUM_ACCTS];
    logic [FW-1:0]     acct_fails_q [NUM_ACCTS];
    logic              acct_lock_q  [NUM_ACCTS];

    logic [IDXW-1:0]   idx_q, idx_d;
    logic              miss_q, miss_d;
    logic [1:0]        req_op_q, req_op_d;
    logic [CARD_W-1:0] req_card_q, req_card_d;
    logic [PIN_W-1:0]  req_pin_q, req_pin_d;
    logic [AMT_W-1:0]  req_amt_q, req_amt_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_status_q, rsp_status_d;
    logic [BAL_W-1:0]  rsp_balance_q, rsp_balance_d;
    logic [PIN_W-1:0]  rsp_pin_q, rsp_pin_d;

    logic              init_fire;
    logic              req_fire;
    logic              hit;
    logic              last;
    logic [SW-1:0]     sum;
    logic [SW-1:0]     amt_ext;
    logic [FW-1:0]     fails_inc;
    logic              ex_we;
    logic [BAL_W-1:0]  ex_bal;
    logic [FW-1:0]     ex_fails;
    logic              ex_lock;

    assign bus.req_ready   = (state_q == S_IDLE) && !init_we;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_status  = rsp_status_q;
    assign bus.rsp_balance = rsp_balance_q;
    assign bus.rsp_pin     = rsp_pin_q;

    assign init_fire = (state_q == S_IDLE) && init_we;
    assign req_fire  = bus.req_valid && bus.req_ready;
    // Card 0 marks an empty slot, so a zero request card must never hit.
    assign hit       = (acct_card_q[idx_q] == req_card_q) && (req_card_q != '0);
    assign last      = (idx_q == IDXW'(NUM_ACCTS - 1));
    assign amt_ext   = SW'(req_amt_q);
    assign sum       = {1'b0, acct_bal_q[idx_q]} + amt_ext;
    assign fails_inc = acct_fails_q[idx_q] + 1'b1;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        miss_d        = miss_q;
        req_op_d      = req_op_q;
        req_card_d    = req_card_q;
        req_pin_d     = req_pin_q;
        req_amt_d     = req_amt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_status_d  = rsp_status_q;
        rsp_balance_d = rsp_balance_q;
        rsp_pin_d     = rsp_pin_q;
        ex_we         = 1'b0;
        ex_bal        = acct_bal_q[idx_q];
        ex_fails      = acct_fails_q[idx_q];
        ex_lock       = acct_lock_q[idx_q];

        unique case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    req_op_d   = bus.req_op;
                    req_card_d = bus.req_card;
                    req_pin_d  = bus.req_pin;
                    req_amt_d  = bus.req_amount;
                    idx_d      = '0;
                    miss_d     = 1'b0;
                    state_d    = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (hit) begin
                    state_d = S_EXEC;
                end else if (last) begin
                    miss_d  = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_EXEC: begin
                state_d       = S_RESP;
                rsp_valid_d   = 1'b1;
                rsp_balance_d = acct_bal_q[idx_q];
                rsp_pin_d     = acct_pin_q[idx_q];
                if (miss_q) begin
                    rsp_status_d  = ST_NOCARD;
                    rsp_balance_d = '0;
                    rsp_pin_d     = '0;
                end else if (acct_lock_q[idx_q]) begin
                    rsp_status_d = ST_LOCKED;
                end else if (req_pin_q != acct_pin_q[idx_q]) begin
                    rsp_status_d = ST_BADPIN;
                    ex_we        = 1'b1;
                    ex_fails     = fails_inc;
                    ex_lock      = (fails_inc >= FW'(MAX_TRIES));
                end else begin
                    ex_we        = 1'b1;
                    ex_fails     = '0;
                    rsp_status_d = ST_OK;
                    unique case (req_op_q)
                        OP_DEP: begin
                            if (sum[BAL_W]) begin
                                rsp_status_d = ST_OVFL;
                            end else begin
                                ex_bal        = sum[BAL_W-1:0];
                                rsp_balance_d = sum[BAL_W-1:0];
                            end
                        end
                        OP_WDR: begin
                            if (amt_ext > {1'b0, acct_bal_q[idx_q]}) begin
                                rsp_status_d = ST_INSUFF;
                            end else begin
                                ex_bal        = acct_bal_q[idx_q] - BAL_W'(req_amt_q);
                                rsp_balance_d = ex_bal;
                            end
                        end
                        OP_AUTH, OP_QUERY: ;
                        default: ;
                    endcase
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            miss_q        <= 1'b0;
            req_op_q      <= '0;
            req_card_q    <= '0;
            req_pin_q     <= '0;
            req_amt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= '0;
            rsp_balance_q <= '0;
            rsp_pin_q     <= '0;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                acct_card_q[i]  <= '0;
                acct_pin_q[i]   <= '0;
                acct_bal_q[i]   <= '0;
                acct_fails_q[i] <= '0;
                acct_lock_q[i]  <= 1'b0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            miss_q        <= miss_d;
            req_op_q      <= req_op_d;
            req_card_q    <= req_card_d;
            req_pin_q     <= req_pin_d;
            req_amt_q     <= req_amt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_balance_q <= rsp_balance_d;
            rsp_pin_q     <= rsp_pin_d;
            if (init_fire && (32'(init_idx) < NUM_ACCTS)) begin
                acct_card_q[init_idx]  <= init_card;
                acct_pin_q[init_idx]   <= init_pin;
                acct_bal_q[init_idx]   <= init_bal;
                acct_fails_q[init_idx] <= '0;
                acct_lock_q[init_idx]  <= 1'b0;
            end
            if (ex_we) begin
                acct_bal_q[idx_q]   <= ex_bal;
                acct_fails_q[idx_q] <= ex_fails;
                acct_lock_q[idx_q]  <= ex_lock;
            end
        end
    end
endmodule

// File: tb/tb_atm_account_ledger.sv
// Scoreboard bench for atm_account_ledger: expected responses are queued at
// request time and checked, with latency, when the response handshakes.
module tb_atm_account_ledger;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_we = 1'b0;
    logic [1:0] init_idx = '0;
    logic [7:0] init_card = '0;
    logic [3:0] init_pin = '0;
    logic [7:0] init_bal = '0;

    atm_account_ledger_if bus ();

    atm_account_ledger dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_card (init_card),
        .init_pin  (init_pin),
        .init_bal  (init_bal),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [7:0] bal;
        logic [3:0] pin;
        int         lat;
        int         t_acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic prev_v = 1'b0;
    int   first_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_v) first_cyc = cyc;
            prev_v = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("status", bus.rsp_status, e.st);
                    check("balance", bus.rsp_balance, e.bal);
                    check("pin", bus.rsp_pin, e.pin);
                    check("latency", first_cyc - e.t_acc, e.lat);
                end
            end
        end
    end

    task automatic load(input logic [1:0] idx, input logic [7:0] card,
                        input logic [3:0] pin, input logic [7:0] bal);
        @(negedge clk);
        init_we   = 1'b1;
        init_idx  = idx;
        init_card = card;
        init_pin  = pin;
        init_bal  = bal;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [7:0] card,
                         input logic [3:0] pin, input logic [4:0] amt,
                         output int t_acc);
        @(negedge clk);
        check("req_ready", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_card   = card;
        bus.req_pin    = pin;
        bus.req_amount = amt;
        t_acc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] card,
                         input logic [3:0] pin, input logic [4:0] amt,
                         input logic [2:0] st, input logic [7:0] bal,
                         input logic [3:0] epin, input int lat);
        exp_t e;
        int   t;
        e.st  = st;
        e.bal = bal;
        e.pin = epin;
        e.lat = lat;
        e.t_acc = cyc + 1;
        sb.push_back(e);
        drive(op, card, pin, amt, t);
        if (t != e.t_acc) sb[sb.size() - 1].t_acc = t;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [7:0] card,
                          input logic [3:0] pin, input logic [4:0] amt,
                          input logic [2:0] st, input logic [7:0] bal,
                          input logic [3:0] epin, input int lat);
        issue(op, card, pin, amt, st, bal, epin, lat);
        wait_done();
    endtask

    initial begin
        int t;
        int k;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_card   = '0;
        bus.req_pin    = '0;
        bus.req_amount = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_status", bus.rsp_status, 0);
        check("rst_rsp_balance", bus.rsp_balance, 0);
        check("rst_rsp_pin", bus.rsp_pin, 0);
        check("rst_req_ready", bus.req_ready, 1);

        load(2'd0, 8'h2A, 4'd5, 8'd100);
        do_req(2'b00, 8'h2A, 4'd5, 5'd0, 3'd0, 8'd100, 4'd5, 3);

        load(2'd2, 8'h33, 4'd9, 8'd250);
        do_req(2'b01, 8'h33, 4'd9, 5'd10, 3'd5, 8'd250, 4'd9, 5);
        do_req(2'b01, 8'h33, 4'd9, 5'd5, 3'd0, 8'd255, 4'd9, 5);

        load(2'd1, 8'h44, 4'd3, 8'd20);
        do_req(2'b10, 8'h44, 4'd3, 5'd31, 3'd4, 8'd20, 4'd3, 4);
        do_req(2'b10, 8'h44, 4'd3, 5'd20, 3'd0, 8'd0, 4'd3, 4);
        do_req(2'b01, 8'h44, 4'd3, 5'd0, 3'd0, 8'd0, 4'd3, 4);
        do_req(2'b11, 8'h44, 4'd3, 5'd0, 3'd0, 8'd0, 4'd3, 4);

        repeat (3) do_req(2'b00, 8'h2A, 4'd6, 5'd0, 3'd2, 8'd100, 4'd5, 3);
        do_req(2'b00, 8'h2A, 4'd5, 5'd0, 3'd3, 8'd100, 4'd5, 3);
        load(2'd0, 8'h2A, 4'd5, 8'd100);
        do_req(2'b00, 8'h2A, 4'd5, 5'd0, 3'd0, 8'd100, 4'd5, 3);

        do_req(2'b00, 8'h77, 4'd1, 5'd0, 3'd1, 8'd0, 4'd0, 6);
        do_req(2'b11, 8'h00, 4'd0, 5'd0, 3'd1, 8'd0, 4'd0, 6);

        bus.rsp_ready = 1'b0;
        issue(2'b11, 8'h33, 4'd9, 5'd0, 3'd0, 8'd255, 4'd9, 5);
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("hold_seen", bus.rsp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_status", bus.rsp_status, 0);
            check("hold_balance", bus.rsp_balance, 255);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        wait_done();

        drive(2'b01, 8'h44, 4'd3, 5'd7, t);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_req_ready", bus.req_ready, 1);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_rsp_valid", bus.rsp_valid, 0);
        do_req(2'b11, 8'h44, 4'd3, 5'd0, 3'd1, 8'd0, 4'd0, 6);
        do_req(2'b11, 8'h2A, 4'd5, 5'd0, 3'd1, 8'd0, 4'd0, 6);
        load(2'd3, 8'h55, 4'd2, 8'd9);
        do_req(2'b10, 8'h55, 4'd2, 5'd9, 3'd0, 8'd0, 4'd2, 6);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
